// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state constants are also consumed by the optional checksum path (IMEM_LOADER_CHECKSUM_EN).
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHK   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Plain vector constants so the FSM register stays a legacy-friendly logic [1:0]
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_CHK   = CHK;
    localparam logic [1:0] ST_DRAIN = DRAIN;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: gathers four accepted bytes MSB-first into a 32-bit word.
// Used for both payload words and the checksum trailer.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_accept,
    input  logic [7:0] i_data,
    output word_t      o_word,
    output logic       o_word_valid,
    output logic       o_last_byte
);

    logic [1:0] r_cnt;
    word_t      r_shift;
    logic       r_valid;
    logic       w_last;

    assign w_last = i_accept && (r_cnt == 2'(WORD_BYTES - 1));

    // The strobe is registered so it lines up with the fully shifted word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (i_accept) begin
                r_shift <= {r_shift[23:0], i_data};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_valid;
    assign o_last_byte  = w_last;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory while holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to add a 32-bit additive checksum trailer check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int HOLD_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [7:0]        i_in_data,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [ADDR_W:0] DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WCNT_ONE   = (ADDR_W + 1)'(1);
    localparam int              DCW        = $clog2(HOLD_CYC + 1) + 1;
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(HOLD_CYC);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DCW-1:0]    r_dcnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_hold;

    logic              w_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_word;
    word_t             w_word;
    logic              w_word_valid;
    logic              w_last_byte;

`ifdef IMEM_LOADER_CHECKSUM_EN
    word_t             r_sum;
    logic              r_word_is_chk;

    assign w_ready = (r_state == ST_LOAD) || (r_state == ST_CHK);
`else
    assign w_ready = (r_state == ST_LOAD);
`endif

    assign w_accept    = i_in_valid && w_ready;
    assign w_start_ok  = (r_state == ST_IDLE) && i_start && (i_len <= DEPTH);
    assign w_last_word = ((r_wcnt + WCNT_ONE) == r_len);

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_start_ok),
        .i_accept     (w_accept),
        .i_data       (i_in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last_byte  (w_last_byte)
    );

    // cpu_hold comes out of reset high so the core stays parked until the first load finishes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_wcnt  <= '0;
            r_addr  <= '0;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len > DEPTH) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err   <= 1'b0;
                            r_len   <= i_len;
                            r_wcnt  <= '0;
                            r_addr  <= '0;
                            r_dcnt  <= '0;
                            r_busy  <= 1'b1;
                            r_hold  <= 1'b1;
                            r_state <= (i_len == '0) ? ST_DRAIN : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_last_byte) begin
                        r_addr <= r_wcnt[ADDR_W-1:0];
                        r_wcnt <= r_wcnt + WCNT_ONE;
                        if (w_last_word) begin
                            r_dcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= ST_CHK;
`else
                            r_state <= ST_DRAIN;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_last_byte) begin
                        r_dcnt  <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
`endif
                ST_DRAIN: begin
                    // The write cycle itself is the first DRAIN cycle, then HOLD_CYC more
                    if (r_dcnt == DRAIN_LAST) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_hold  <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + DCW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_word_valid && r_word_is_chk && (w_word != r_sum)) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Tag each packed word with its origin so the trailer never reaches memory
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum         <= '0;
            r_word_is_chk <= 1'b0;
        end else begin
            if (w_last_byte) begin
                r_word_is_chk <= (r_state == ST_CHK);
            end
            if (w_start_ok) begin
                r_sum <= '0;
            end else if (w_word_valid && !r_word_is_chk) begin
                r_sum <= r_sum + w_word;
            end
        end
    end

    assign o_imem_we = w_word_valid && !r_word_is_chk;
`else
    assign o_imem_we = w_word_valid;
`endif

    assign o_in_ready   = w_ready;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = w_word;
    assign o_cpu_hold   = r_hold;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
